// File: rtl/sram_dp.sv
// rtl/sram_dp.sv - single-clock simple dual-port SRAM with byte enables, init-to-zero sequencer and optional output register
//
// Parameters:
//   depth   - number of words (>= 2, any value)
//   width   - word width in bits (multiple of 8)
//   rd_mode - same-address collision policy: 0 = read-first, 1 = write-first
//   out_reg - 1 adds a second output pipeline stage (read latency 2 instead of 1)
// Ports:
//   clk, rst_n          - clock (rising edge) and asynchronous active-low reset
//   we, wadd, data_in,
//   wbe                 - write request, address, data and per-byte enables
//   re, radd            - read request and address
//   data_out, rvalid    - read data (held between reads) and one-cycle valid pulse
//   busy                - high while the array is being cleared; requests are ignored

module sram_dp #(
    parameter int depth   = 16,
    parameter int width   = 16,
    parameter int rd_mode = 0,
    parameter int out_reg = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(depth)-1:0]   wadd,
    input  logic [width-1:0]           data_in,
    input  logic [width/8-1:0]         wbe,
    input  logic                       re,
    input  logic [$clog2(depth)-1:0]   radd,
    output logic [width-1:0]           data_out,
    output logic                       rvalid,
    output logic                       busy
);

    localparam int aw = $clog2(depth);
    localparam int nb = width / 8;
    // depth widened by one bit so the range compare works when depth is a power of two
    localparam logic [aw:0] depth_w = (aw + 1)'(depth);

    localparam logic [0:0] st_init = 1'b0;
    localparam logic [0:0] st_idle = 1'b1;

    logic [width-1:0] mem [depth];
    logic [0:0]       state;
    logic [aw-1:0]    cnt;

    logic             idle;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_go;
    logic             rd_go;
    logic [width-1:0] rd_word;

    logic             v1;
    logic [width-1:0] d1;

    assign idle        = (state == st_idle);
    assign busy        = (state == st_init);
    assign wr_in_range = ({1'b0, wadd} < depth_w);
    assign rd_in_range = ({1'b0, radd} < depth_w);
    assign wr_go       = idle && we && wr_in_range;
    assign rd_go       = idle && re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_init;
            cnt   <= '0;
        end else if (state == st_init) begin
            if (cnt == aw'(depth - 1)) begin
                state <= st_idle;
            end
            cnt <= cnt + aw'(1);
        end
    end

    // Array has no reset; it is cleared by the INIT sweep once rst_n is high.
    always_ff @(posedge clk) begin
        if (rst_n && (state == st_init)) begin
            mem[cnt] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < nb; i++) begin
                if (wbe[i]) begin
                    mem[wadd][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Out-of-range reads return zero; write-first merges the incoming bytes on a same-address hit.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[radd];
            if ((rd_mode == 1) && we && (wadd == radd)) begin
                for (int i = 0; i < nb; i++) begin
                    if (wbe[i]) begin
                        rd_word[8*i +: 8] = data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_go;
            if (rd_go) begin
                d1 <= rd_word;
            end
        end
    end

    generate
        if (out_reg != 0) begin : g_out_reg
            logic             v2;
            logic [width-1:0] d2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign data_out = d2;
            assign rvalid   = v2;
        end else begin : g_no_out_reg
            assign data_out = d1;
            assign rvalid   = v1;
        end
    endgenerate

endmodule
